saph_pix_deser: RTL

- Pixel deserializer sitting directly upstream of the color unpacker.
- Consumes a stream of WORD_W-bit framebuffer/texture words and slices each into pixels of 1/2/4/8/16/32 bits.
- Emits one zero-extended 32-bit packed pixel per handshake for the unpacker's packed-color input.
- Each span is programmed with a bit depth and a pixel count, and ends with a marked last pixel.

---
 rtl/saph_pix_deser.sv | 135 +++++++++++++
 1 files changed

// File: rtl/saph_pix_deser.sv
// Pixel deserializer: slices WORD_W-bit words into 1..32 bpp pixels, zero-extended to 32 bits.
// Optional SAPH_PIX_DESER_SKIP_EN adds cfg_skip: the first word of a span starts at a nonzero slice.
module saph_pix_deser #(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [2:0]        cfg_bpp_log2,
  input  logic [15:0]       cfg_count,
`ifdef SAPH_PIX_DESER_SKIP_EN
  input  logic [4:0]        cfg_skip,
`endif
  output logic              cfg_err,
  output logic              busy,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [31:0]       pix_data,
  output logic              pix_last
);

  localparam int IW = $clog2(WORD_W);
  localparam logic [IW:0] SLICES_MAX = (IW+1)'(WORD_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        bpp_q;
  logic [15:0]       rem_q;
  logic [IW-1:0]     idx_q;
  logic [WORD_W-1:0] buf_q;
  logic              buf_vld_q;
  logic              err_q;

  logic              cfg_bad;
  logic [IW-1:0]     last_slice;
  logic              at_last;
  logic              pix_hs;
  logic              word_hs;
  logic              final_pix;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     sh;
  logic [31:0]       pix_raw;
  logic [31:0]       mask;

`ifdef SAPH_PIX_DESER_SKIP_EN
  logic [IW:0] cfg_slices;
  assign cfg_slices = SLICES_MAX >> cfg_bpp_log2;
  assign cfg_bad    = (cfg_bpp_log2 > 3'd5) || ((IW+1)'(cfg_skip) >= cfg_slices);
`else
  assign cfg_bad    = (cfg_bpp_log2 > 3'd5);
`endif

  assign last_slice = IW'((SLICES_MAX >> bpp_q) - (IW+1)'(1));
  assign at_last    = (idx_q == last_slice);
  assign pix_hs     = buf_vld_q && pix_ready;
  assign final_pix  = pix_hs && (rem_q == 16'd1);

  // Refill either into an empty buffer or in the same cycle the last slice leaves.
  assign word_ready = (state_q == RUN) &&
                      (!buf_vld_q || (pix_ready && at_last && (rem_q > 16'd1)));
  assign word_hs    = word_valid && word_ready;

  assign sel     = MSB_FIRST ? (last_slice - idx_q) : idx_q;
  assign sh      = sel << bpp_q;
  assign pix_raw = 32'(buf_q >> sh);
  assign mask    = 32'hFFFF_FFFF >> (6'd32 - (6'd1 << bpp_q));

  assign pix_valid = buf_vld_q;
  assign pix_data  = buf_vld_q ? (pix_raw & mask) : 32'h0;
  assign pix_last  = buf_vld_q && (rem_q == 16'd1);
  assign busy      = (state_q == RUN);
  assign cfg_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_load && !cfg_bad && (cfg_count != 16'd0)) state_d = RUN;
      RUN:  if (final_pix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bpp_q     <= 3'd0;
      rem_q     <= 16'd0;
      idx_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && cfg_load && cfg_bad;
      if (state_q == IDLE) begin
        if (cfg_load && !cfg_bad) begin
          bpp_q <= cfg_bpp_log2;
          rem_q <= cfg_count;
`ifdef SAPH_PIX_DESER_SKIP_EN
          idx_q <= IW'(cfg_skip);
`else
          idx_q <= '0;
`endif
        end
      end else begin
        if (pix_hs) rem_q <= rem_q - 16'd1;
        // Final pixel drops any unused slices so the next span starts on a fresh word.
        if (final_pix) begin
          buf_vld_q <= 1'b0;
          idx_q     <= '0;
        end else if (word_hs) begin
          buf_q     <= word_data;
          buf_vld_q <= 1'b1;
          if (pix_hs) idx_q <= '0;
        end else if (pix_hs) begin
          if (at_last) begin
            buf_vld_q <= 1'b0;
            idx_q     <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
      end
    end
  end

endmodule
